ref_row_fetcher: RTL
====================

Name: ref_row_fetcher

Overview:
- Upstream feeder for the 15-row byte shift register that supplies the 8x8 interpolation filters.
- Fetches the 15 reference rows needed for one 8x8 prediction block (8 rows plus 7 filter-tap rows) from pixel memory over a request/grant/response interface.
- Presents each returned 64-bit row with a one-cycle active-low load strobe.
- Announces block completion to the filter controller with a valid/ack handshake.

Parameters:
ROWS, 15, rows fetched per block (8 output rows + 7 tap rows)
DATA_W, 64, row width in bits (8 pixels x 8 bits)
ADDR_W, 32, memory byte-address width
MAX_OUTST, 4, maximum outstanding memory requests (power of 2, >=1)

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- start  input  1  pulse: begin fetch of one block; sampled only in IDLE.
- base_addr  input  ADDR_W  address of first row; captured on accepted start.
- stride  input  ADDR_W  byte distance between rows; captured on accepted start.
- mem_req  output  1  read request valid.
- mem_addr  output  ADDR_W  read address.
- mem_gnt  input  1  request accepted when mem_req && mem_gnt.
- mem_rvalid  input  1  read data valid; responses return in request order.
- mem_rdata  input  DATA_W  read data.
- row_out  output  DATA_W  row to shift register.
- row_load_L  output  1  active-low, one cycle per row.
- block_valid  output  1  all ROWS rows delivered.
- block_ack  input  1  consumer has taken the block.
- busy  output  1  high in any state other than IDLE.
- protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0 except row_load_L = 1. All counters 0, state IDLE.
- Reset mid-operation aborts the block. Responses arriving after reset count as stray (see protocol_err).
- All outputs are registered.
- State IDLE: on start, capture base_addr/stride, clear issue_cnt/resp_cnt, set next_addr = base_addr, go to FETCH. start is ignored in every other state.
- State FETCH:
  - mem_req = 1 while issue_cnt < ROWS and outstanding < MAX_OUTST; mem_addr = next_addr.
  - On mem_req && mem_gnt: issue_cnt++, next_addr += stride (mod 2^ADDR_W, wrap silently), outstanding++.
  - mem_req/mem_addr must stay stable until granted.
  - When issue_cnt reaches ROWS, go to DRAIN; mem_req deasserts the same cycle issue_cnt hits ROWS.
- State DRAIN: no requests. When resp_cnt reaches ROWS, go to DONE.
- Response handling (FETCH or DRAIN):
  - On mem_rvalid: next cycle row_out = mem_rdata and row_load_L = 0 for exactly one cycle; resp_cnt++, outstanding--.
  - Simultaneous grant and rvalid in the same cycle leave outstanding unchanged.
  - Back-to-back rvalids produce back-to-back load pulses. row_out holds its last value otherwise.
  - Load latency: 1 cycle from rvalid.
- State DONE:
  - block_valid = 1, asserted on the cycle after the final row_load_L pulse. It holds until block_ack is sampled high.
  - On block_ack: block_valid = 0 next cycle, go to IDLE.
  - block_ack outside DONE is ignored.
  - start arriving in the same cycle as block_ack is ignored; start is accepted only from IDLE.
- protocol_err sets on:
  - mem_rvalid with outstanding == 0 (including in IDLE/DONE); the stray data is discarded, with no load pulse.
  - mem_gnt while mem_req == 0.
- Widths:
  - issue_cnt and resp_cnt are 4 bits.
  - outstanding is clog2(MAX_OUTST)+1 bits and never exceeds MAX_OUTST.
- Boundary cases:
  - MAX_OUTST = 1 serialises fully.
  - stride = 0 legally fetches the same row 15 times.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3);
  - the ROWS default;
  - row/pixel width constants shared with the shift register and filters.
- One natural sub-module, ref_req_tracker: the outstanding-request counter, which produces can_issue and stray-response detection. Everything else stays in the top FSM.

Test Plan:
- Zero-wait memory (gnt tied 1, rvalid 2 cycles after grant), base=0x1000, stride=0x40:
  - addresses 0x1000..0x1380 step 0x40, issued in order;
  - 15 row_load_L pulses with row_out matching;
  - block_valid rises one cycle after 15th pulse.
- Backpressure with gnt low for 3 cycles each request, MAX_OUTST=4, response delay 10 cycles:
  - outstanding never exceeds 4; mem_req/mem_addr stable while ungranted;
  - 15 rows delivered in order.
- Hold block_ack low for 20 cycles in DONE, pulse start mid-wait:
  - block_valid stays 1, no new requests;
  - after ack, IDLE; a subsequent start fetches a new block.
- Assert reset_L low after 7 rows:
  - immediately mem_req=0, row_load_L=1, block_valid=0, busy=0;
  - late rvalid after release sets protocol_err with no load pulse.
- Address wrap: base=0xFFFFFFC0, stride=0x40 → second address 0x00000000; 15 rows complete normally.
- Simultaneous grant and rvalid every cycle:
  - outstanding constant, back-to-back load pulses;
  - completion within ROWS + response latency + 2 cycles.

Source files
------------

// File: rtl/ref_row_fetcher_pkg.sv
// Shared types and constants for the reference-row fetcher, the row shift
// register and the 8x8 interpolation filters.
package ref_row_fetcher_pkg;

    localparam int PIX_W       = 8;
    localparam int PIX_PER_ROW = 8;
    localparam int ROW_W       = PIX_W * PIX_PER_ROW;

    // 8 output rows plus 7 filter-tap rows.
    localparam int ROWS_DEF = 15;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width able to hold 0..max_outst inclusive.
    function automatic int outst_w(input int max_outst);
        return $clog2(max_outst) + 1;
    endfunction

endpackage

// File: rtl/ref_row_fetcher_if.sv
// Pixel-memory read port: request/grant on the address side, in-order
// valid-only responses on the data side.
interface ref_row_fetcher_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ref_req_tracker.sv
// Outstanding-request counter: decides whether another request may be issued
// next cycle and classifies each response as accepted or stray.
module ref_req_tracker
    import ref_row_fetcher_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic clock,
    input  logic reset_L,
    input  logic i_issue,
    input  logic i_rvalid,
    output logic o_can_issue,
    output logic o_resp_accept,
    output logic o_stray
);

    localparam int OW = outst_w(MAX_OUTST);
    localparam logic [OW-1:0] LIMIT = OW'(MAX_OUTST);

    logic [OW-1:0] r_outst;
    logic [OW-1:0] w_outst_nxt;

    assign o_stray       = i_rvalid && (r_outst == '0);
    assign o_resp_accept = i_rvalid && (r_outst != '0);

    // NOTE: give every combinational output a default before any branch so no
    // path leaves it unassigned and a latch is inferred.
    always_comb begin
        w_outst_nxt = r_outst;
        case ({i_issue, o_resp_accept})
            2'b10:   w_outst_nxt = r_outst + OW'(1);
            2'b01:   w_outst_nxt = r_outst - OW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Looks at the post-update count because the request line is registered.
    assign o_can_issue = (w_outst_nxt < LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_nxt;
        end
    end

endmodule

// File: rtl/ref_row_fetcher.sv
// Fetches the reference rows of one 8x8 prediction block, streams them to the
// row shift register with an active-low load strobe, then hands the block off.
module ref_row_fetcher
    import ref_row_fetcher_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int DATA_W    = ROW_W,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clock,
    input  logic                reset_L,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   stride,
    ref_row_fetcher_if.master   mem_bus,
    output logic [DATA_W-1:0]   row_out,
    output logic                row_load_L,
    output logic                block_valid,
    input  logic                block_ack,
    output logic                busy,
    output logic                protocol_err
);

    localparam logic [CNT_W-1:0] ROWS_CNT = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]  r_issue_cnt, w_issue_cnt_nxt;
    logic [CNT_W-1:0]  r_resp_cnt,  w_resp_cnt_nxt;
    logic [ADDR_W-1:0] r_next_addr, w_next_addr_nxt;
    logic [ADDR_W-1:0] r_stride,    w_stride_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_row_out;
    logic              r_row_load_L;
    logic              r_block_valid;
    logic              r_busy;
    logic              r_protocol_err;

    logic w_issue;
    logic w_stray_gnt;
    logic w_can_issue;
    logic w_resp_accept;
    logic w_stray_rsp;

    assign w_issue     = r_mem_req && mem_bus.mem_gnt;
    assign w_stray_gnt = mem_bus.mem_gnt && !r_mem_req;

    ref_req_tracker #(
        .MAX_OUTST (MAX_OUTST)
    ) u_tracker (
        .clock         (clock),
        .reset_L       (reset_L),
        .i_issue       (w_issue),
        .i_rvalid      (mem_bus.mem_rvalid),
        .o_can_issue   (w_can_issue),
        .o_resp_accept (w_resp_accept),
        .o_stray       (w_stray_rsp)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_issue && (r_issue_cnt == LAST_ROW)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_resp_cnt == ROWS_CNT) w_state_nxt = ST_DONE;
            ST_DONE:  if (block_ack) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the counters and the registered request port; the
    // request is computed from post-edge state so it drops on the final grant.
    always_comb begin
        w_issue_cnt_nxt = r_issue_cnt;
        w_resp_cnt_nxt  = r_resp_cnt;
        w_next_addr_nxt = r_next_addr;
        w_stride_nxt    = r_stride;
        if ((r_state == ST_IDLE) && start) begin
            w_issue_cnt_nxt = '0;
            w_resp_cnt_nxt  = '0;
            w_next_addr_nxt = base_addr;
            w_stride_nxt    = stride;
        end else begin
            if (w_issue) begin
                w_issue_cnt_nxt = r_issue_cnt + CNT_W'(1);
                w_next_addr_nxt = r_next_addr + r_stride;
            end
            if (w_resp_accept) begin
                w_resp_cnt_nxt = r_resp_cnt + CNT_W'(1);
            end
        end
        w_mem_req_nxt  = (w_state_nxt == ST_FETCH) && (w_issue_cnt_nxt < ROWS_CNT) && w_can_issue;
        w_mem_addr_nxt = w_mem_req_nxt ? w_next_addr_nxt : r_mem_addr;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_issue_cnt    <= '0;
            r_resp_cnt     <= '0;
            r_next_addr    <= '0;
            r_stride       <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_row_out      <= '0;
            r_row_load_L   <= 1'b1;
            r_block_valid  <= 1'b0;
            r_busy         <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_issue_cnt    <= w_issue_cnt_nxt;
            r_resp_cnt     <= w_resp_cnt_nxt;
            r_next_addr    <= w_next_addr_nxt;
            r_stride       <= w_stride_nxt;
            r_mem_req      <= w_mem_req_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            if (w_resp_accept) begin
                r_row_out <= mem_bus.mem_rdata;
            end
            r_row_load_L   <= !w_resp_accept;
            r_block_valid  <= (w_state_nxt == ST_DONE);
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_protocol_err <= r_protocol_err || w_stray_rsp || w_stray_gnt;
        end
    end

    assign mem_bus.mem_req  = r_mem_req;
    assign mem_bus.mem_addr = r_mem_addr;
    assign row_out          = r_row_out;
    assign row_load_L       = r_row_load_L;
    assign block_valid      = r_block_valid;
    assign busy             = r_busy;
    assign protocol_err     = r_protocol_err;

endmodule
